// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries fetch-time predictions to EX, detects mispredictions,
// drives the fetch redirect, emits predictor training packets and keeps saturating counters.
module branch_resolve_unit #(
  parameter int SET_ADDR_LEN = 6,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Stall,
  input  logic                    Flush,
  input  logic [31:0]             PCF,
  input  logic                    pred_hit_F,
  input  logic                    pred_taken_F,
  input  logic [31:0]             pred_tgt_F,
  input  logic [2:0]              BranchTypeE,
  input  logic                    BranchE,
  input  logic [31:0]             BranchTarget,
  input  logic                    cnt_clr,
  output logic [31:0]             PCE,
  output logic                    redirect,
  output logic [31:0]             redirect_pc,
  output logic                    upd_valid,
  output logic                    upd_alloc,
  output logic                    upd_inval,
  output logic                    upd_taken,
  output logic [31:0]             upd_pc,
  output logic [SET_ADDR_LEN-1:0] upd_set,
  output logic [31:0]             upd_target,
  output logic [CNT_W-1:0]        cnt_branch,
  output logic [CNT_W-1:0]        cnt_mispred
);

  logic [31:0]      pcD_q, pcD_d, pcE_q, pcE_d;
  logic [31:0]      tgtD_q, tgtD_d, tgtE_q, tgtE_d;
  logic             vldD_q, vldD_d, hitD_q, hitD_d, takenD_q, takenD_d;
  logic             vldE_q, vldE_d, hitE_q, hitE_d, takenE_q, takenE_d;
  logic [CNT_W-1:0] cntBranch_q, cntBranch_d, cntMispred_q, cntMispred_d;

  logic        isBranch;
  logic        predTaken;
  logic [31:0] seqPc;

  assign isBranch  = vldE_q && (BranchTypeE != 3'd0);
  assign predTaken = hitE_q && takenE_q;
  assign seqPc     = pcE_q + 32'd4;

  // Flush only bubbles the metadata; PCs keep flowing so PCE stays meaningful.
  always_comb begin
    pcD_d    = pcD_q;
    tgtD_d   = tgtD_q;
    vldD_d   = vldD_q;
    hitD_d   = hitD_q;
    takenD_d = takenD_q;
    pcE_d    = pcE_q;
    tgtE_d   = tgtE_q;
    vldE_d   = vldE_q;
    hitE_d   = hitE_q;
    takenE_d = takenE_q;
    if (!Stall) begin
      pcD_d    = PCF;
      tgtD_d   = pred_tgt_F;
      vldD_d   = 1'b1;
      hitD_d   = pred_hit_F;
      takenD_d = pred_taken_F;
      pcE_d    = pcD_q;
      tgtE_d   = tgtD_q;
      vldE_d   = vldD_q;
      hitE_d   = hitD_q;
      takenE_d = takenD_q;
      if (Flush) begin
        vldD_d   = 1'b0;
        hitD_d   = 1'b0;
        takenD_d = 1'b0;
        vldE_d   = 1'b0;
        hitE_d   = 1'b0;
        takenE_d = 1'b0;
      end
    end
  end

  // Redirect cases in priority order; the fallback target is always the sequential PC.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = seqPc;
    if (isBranch && BranchE && !predTaken) begin
      redirect    = 1'b1;
      redirect_pc = BranchTarget;
    end else if (isBranch && BranchE && predTaken && (tgtE_q != BranchTarget)) begin
      redirect    = 1'b1;
      redirect_pc = BranchTarget;
    end else if (isBranch && !BranchE && predTaken) begin
      redirect    = 1'b1;
      redirect_pc = seqPc;
    end else if (!isBranch && vldE_q && predTaken) begin
      redirect    = 1'b1;
      redirect_pc = seqPc;
    end
  end

  // Training is suppressed during Stall so each instruction trains exactly once.
  always_comb begin
    upd_valid = 1'b0;
    upd_alloc = 1'b0;
    upd_inval = 1'b0;
    upd_taken = 1'b0;
    if (!Stall) begin
      if (isBranch) begin
        upd_valid = 1'b1;
        upd_alloc = !hitE_q;
        upd_taken = BranchE;
      end else if (vldE_q && hitE_q) begin
        upd_valid = 1'b1;
        upd_inval = 1'b1;
      end
    end
  end

  assign PCE        = pcE_q;
  assign upd_pc     = pcE_q;
  assign upd_set    = pcE_q[SET_ADDR_LEN-1:0];
  assign upd_target = BranchTarget;

  // Counters saturate at all-ones; clear works even while stalled.
  always_comb begin
    cntBranch_d  = cntBranch_q;
    cntMispred_d = cntMispred_q;
    if (cnt_clr) begin
      cntBranch_d  = '0;
      cntMispred_d = '0;
    end else if (!Stall) begin
      if (isBranch && !(&cntBranch_q))
        cntBranch_d = cntBranch_q + CNT_W'(1);
      if (redirect && !(&cntMispred_q))
        cntMispred_d = cntMispred_q + CNT_W'(1);
    end
  end

  assign cnt_branch  = cntBranch_q;
  assign cnt_mispred = cntMispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcD_q        <= '0;
      tgtD_q       <= '0;
      vldD_q       <= 1'b0;
      hitD_q       <= 1'b0;
      takenD_q     <= 1'b0;
      pcE_q        <= '0;
      tgtE_q       <= '0;
      vldE_q       <= 1'b0;
      hitE_q       <= 1'b0;
      takenE_q     <= 1'b0;
      cntBranch_q  <= '0;
      cntMispred_q <= '0;
    end else begin
      pcD_q        <= pcD_d;
      tgtD_q       <= tgtD_d;
      vldD_q       <= vldD_d;
      hitD_q       <= hitD_d;
      takenD_q     <= takenD_d;
      pcE_q        <= pcE_d;
      tgtE_q       <= tgtE_d;
      vldE_q       <= vldE_d;
      hitE_q       <= hitE_d;
      takenE_q     <= takenE_d;
      cntBranch_q  <= cntBranch_d;
      cntMispred_q <= cntMispred_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by random traffic,
// compared against a slot-based reference model of the fetch-to-EX prediction path.
module tb_branch_resolve_unit;

  localparam int CW  = 4;
  localparam int SAL = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, Stall, Flush, pred_hit_F, pred_taken_F, BranchE, cnt_clr;
  logic [31:0]     PCF, pred_tgt_F, BranchTarget;
  logic [2:0]      BranchTypeE;
  logic [31:0]     PCE, redirect_pc, upd_pc, upd_target;
  logic            redirect, upd_valid, upd_alloc, upd_inval, upd_taken;
  logic [SAL-1:0]  upd_set;
  logic [CW-1:0]   cnt_branch, cnt_mispred;

  branch_resolve_unit #(.SET_ADDR_LEN(SAL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .PCF(PCF),
    .pred_hit_F(pred_hit_F), .pred_taken_F(pred_taken_F), .pred_tgt_F(pred_tgt_F),
    .BranchTypeE(BranchTypeE), .BranchE(BranchE), .BranchTarget(BranchTarget),
    .cnt_clr(cnt_clr), .PCE(PCE), .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_alloc(upd_alloc), .upd_inval(upd_inval),
    .upd_taken(upd_taken), .upd_pc(upd_pc), .upd_set(upd_set), .upd_target(upd_target),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    bit          vld;
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
  } slot_t;

  // slots[0] = instruction in ID, slots[1] = instruction in EX
  slot_t slots [2];
  int    mBr, mMis;
  int    nCmp, nFail;

  bit          eBr, eRedir, eUv, eAl, eIn, eTk;
  logic [31:0] ePc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      slots[i].pc = 0; slots[i].vld = 0; slots[i].hit = 0; slots[i].taken = 0; slots[i].tgt = 0;
    end
    mBr = 0;
    mMis = 0;
  endtask

  task automatic checkOutput();
    slot_t ex;
    bit ptk, actualTaken;
    logic [31:0] fallthrough, actualNext, predNext;
    ex = slots[1];
    ptk = ex.hit && ex.taken;
    eBr = ex.vld && (BranchTypeE != 0);
    fallthrough = ex.pc + 32'd4;
    actualTaken = eBr && BranchE;
    // Where fetch should have gone vs where the predictor sent it
    actualNext = actualTaken ? BranchTarget : fallthrough;
    predNext   = ptk ? ex.tgt : fallthrough;
    eRedir = ex.vld && (actualTaken ? (!ptk || predNext != actualNext) : ptk);
    ePc    = eRedir ? actualNext : fallthrough;
    eUv = !Stall && (eBr || (ex.vld && ex.hit));
    eAl = !Stall && eBr && !ex.hit;
    eIn = !Stall && !eBr && ex.vld && ex.hit;
    eTk = !Stall && eBr && BranchE;
    chk("PCE", PCE, ex.pc);
    chk("redirect", redirect, eRedir);
    chk("redirect_pc", redirect_pc, ePc);
    chk("upd_valid", upd_valid, eUv);
    chk("upd_alloc", upd_alloc, eAl);
    chk("upd_inval", upd_inval, eIn);
    chk("upd_taken", upd_taken, eTk);
    chk("upd_pc", upd_pc, ex.pc);
    chk("upd_set", upd_set, ex.pc % (1 << SAL));
    chk("upd_target", upd_target, BranchTarget);
    chk("cnt_branch", cnt_branch, mBr);
    chk("cnt_mispred", cnt_mispred, mMis);
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic clr, input logic r,
                               input logic [31:0] pcf, input logic h, input logic tk,
                               input logic [31:0] tg, input logic [2:0] bty, input logic be,
                               input logic [31:0] bt);
    @(negedge clk);
    Stall = st; Flush = fl; cnt_clr = clr; rst = r;
    PCF = pcf; pred_hit_F = h; pred_taken_F = tk; pred_tgt_F = tg;
    BranchTypeE = bty; BranchE = be; BranchTarget = bt;
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      if (cnt_clr) begin
        mBr = 0; mMis = 0;
      end else if (!Stall) begin
        if (eBr)    mBr  = (mBr  < CMAX) ? mBr + 1  : CMAX;
        if (eRedir) mMis = (mMis < CMAX) ? mMis + 1 : CMAX;
      end
      if (!Stall) begin
        slots[1] = slots[0];
        slots[0].pc = PCF; slots[0].vld = 1; slots[0].hit = pred_hit_F;
        slots[0].taken = pred_taken_F; slots[0].tgt = pred_tgt_F;
        if (Flush) begin
          for (int i = 0; i < 2; i++) begin
            slots[i].vld = 0; slots[i].hit = 0; slots[i].taken = 0;
          end
        end
      end
    end
  endtask

  logic [31:0] tgtSet [4];

  initial begin
    nCmp = 0; nFail = 0;
    tgtSet[0] = 32'h80; tgtSet[1] = 32'h84; tgtSet[2] = 32'h200; tgtSet[3] = 32'h1F0;
    rst = 1; Stall = 0; Flush = 0; cnt_clr = 0; PCF = 0; pred_hit_F = 0; pred_taken_F = 0;
    pred_tgt_F = 0; BranchTypeE = 0; BranchE = 0; BranchTarget = 0;
    @(posedge clk);
    @(posedge clk);
    modelReset();

    // Reset state
    applyStimulus(0, 0, 0, 0, 32'h40, 1, 1, 32'h80, 3'd0, 0, 32'h0);
    chk("rst_redirect", redirect, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_pce", PCE, 0);
    tick();

    // Correctly predicted taken branch
    applyStimulus(0, 0, 0, 0, 32'h48, 0, 0, 32'h0, 3'd0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h40, 1, 1, 32'h80, 3'd1, 1, 32'h80);
    chk("t1_redirect", redirect, 0);
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_taken", upd_taken, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h60, 0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("t1_cnt_branch", cnt_branch, 1);
    tick();

    // Predicted taken, resolved not taken
    applyStimulus(0, 0, 0, 0, 32'h100, 0, 0, 32'h0, 3'd1, 0, 32'h0);
    chk("t2_redirect", redirect, 1);
    chk("t2_redirect_pc", redirect_pc, 32'h44);
    chk("t2_upd_taken", upd_taken, 0);
    tick();

    // Miss on a taken branch, then hit with a stale target
    applyStimulus(0, 0, 0, 0, 32'h60, 0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("t2_cnt_mispred", cnt_mispred, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h100, 1, 1, 32'h1F0, 3'd1, 1, 32'h200);
    chk("t3_alloc_redirect_pc", redirect_pc, 32'h200);
    chk("t3_upd_alloc", upd_alloc, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h10, 1, 1, 32'h80, 3'd0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h10, 1, 1, 32'h80, 3'd1, 1, 32'h200);
    chk("t3_tgt_redirect", redirect, 1);
    chk("t3_tgt_redirect_pc", redirect_pc, 32'h200);
    tick();

    // Alias hit on a non-branch, then the same fetch flushed before EX
    applyStimulus(0, 1, 0, 0, 32'h70, 0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("t4_alias_redirect_pc", redirect_pc, 32'h14);
    chk("t4_upd_inval", upd_inval, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h40, 1, 1, 32'h80, 3'd1, 1, 32'h300);
    chk("t4_flush_redirect", redirect, 0);
    chk("t4_flush_upd_valid", upd_valid, 0);
    tick();

    // Mispredicted branch held in EX by Stall
    applyStimulus(0, 0, 0, 0, 32'h50, 0, 0, 32'h0, 3'd0, 0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 32'h54, 0, 0, 32'h0, 3'd1, 1, 32'h90);
      chk("t5_stall_redirect", redirect, 1);
      chk("t5_stall_upd_valid", upd_valid, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 32'h54, 0, 0, 32'h0, 3'd1, 1, 32'h90);
    chk("t5_release_upd_valid", upd_valid, 1);
    tick();

    // Saturation of the mispredict counter, then a clear while stalled
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 32'h400 + 32'(i * 4), 1, 1, 32'h80, 3'd2, 0, 32'h0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 32'h500, 1, 1, 32'h80, 3'd2, 0, 32'h0);
    chk("t6_sat_mispred", cnt_mispred, 15);
    tick();
    applyStimulus(1, 0, 1, 0, 32'h504, 0, 0, 32'h0, 3'd2, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h504, 0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("t6_clr_mispred", cnt_mispred, 0);
    chk("t6_clr_branch", cnt_branch, 0);
    tick();

    // Reset while stalled discards in-flight predictions
    applyStimulus(1, 0, 0, 1, 32'h600, 1, 1, 32'h80, 3'd1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h604, 0, 0, 32'h0, 3'd1, 1, 32'h700);
    chk("rst_stall_pce", PCE, 0);
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic st, fl, clr, r, h, tk, be;
      logic [2:0] bty;
      st  = ($urandom % 6) == 0;
      fl  = ($urandom % 8) == 0;
      clr = ($urandom % 40) == 0;
      r   = ($urandom % 90) == 0;
      h   = ($urandom % 3) != 0;
      tk  = $urandom % 2;
      be  = $urandom % 2;
      bty = ($urandom % 3 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      applyStimulus(st, fl, clr, r, $urandom, h, tk, tgtSet[$urandom % 4], bty, be,
                    tgtSet[$urandom % 4]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
